// File: rtl/loader_pkg.sv
// Shared types and helpers for the UART program loader.
package loader_pkg;

  // Loader sequencing: header, payload, checksum, then a terminal state.
  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_SUM,
    S_DONE,
    S_ERR
  } loader_state_t;

  // Byte lane that receives the byte at position idx within a word.
  function automatic int lane_sel(input int idx, input bit big_endian, input int word_bytes);
    if (big_endian) return word_bytes - 1 - idx;
    return idx;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Assembles a stream of bytes into words; the completed word is presented
// combinationally in the cycle its last byte is accepted.
module byte_packer
  import loader_pkg::*;
#(
  parameter int WORD_BYTES = 4,
  parameter int BIG_ENDIAN = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [7:0]              byte_i,
  input  logic                    valid_i,
  input  logic                    clear_i,
  output logic [8*WORD_BYTES-1:0] word_o,
  output logic                    word_valid_o
);

  localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [8*WORD_BYTES-1:0] part_q;
  logic                    last;
  int                      lane;

  assign last         = (idx_q == LAST_IDX);
  assign word_valid_o = valid_i & ~clear_i & last;

  // Insert the incoming byte into its lane on top of the partial word.
  always_comb begin
    lane   = lane_sel(int'(idx_q), BIG_ENDIAN != 0, WORD_BYTES);
    word_o = part_q;
    word_o[8*lane +: 8] = byte_i;
  end

  // Byte index: clear wins, otherwise advance and wrap on each accepted byte.
  always_comb begin
    idx_d = idx_q;
    if (clear_i)      idx_d = '0;
    else if (valid_i) idx_d = last ? '0 : idx_q + IDX_W'(1);
  end

  // Index register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) idx_q <= '0;
    else         idx_q <= idx_d;
  end

  // Partial word holds data only; every lane is rewritten before it is used.
  always_ff @(posedge clk_i) begin
    if (valid_i && !clear_i) part_q <= word_o;
  end

endmodule

// File: rtl/prog_loader.sv
// Framed UART program loader: length header, payload words written to
// instruction memory, then an XOR checksum word.
module prog_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int WORD_BYTES = 4,
  parameter int BIG_ENDIAN = 0
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  input  logic                    arm,
  input  logic                    abort,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [8*WORD_BYTES-1:0] mem_data,
  output logic                    busy,
  output logic                    done,
  output logic                    chk_ok,
  output logic                    err_len,
  output logic [ADDR_WIDTH:0]     word_count
);

  localparam int WORD_W = 8 * WORD_BYTES;
  localparam int CMP_W  = (WORD_W > ADDR_WIDTH + 1) ? WORD_W : ADDR_WIDTH + 1;
  localparam logic [CMP_W-1:0] CAPACITY = CMP_W'(1) << ADDR_WIDTH;

  loader_state_t       state_q;
  logic                mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [WORD_W-1:0]   mem_data_q;
  logic [WORD_W-1:0]   chk_q, chk_d;
  logic [ADDR_WIDTH:0] wc_q, wc_d;
  logic [ADDR_WIDTH:0] n_q, n_d;
  logic                chk_ok_q;

  logic                accepting;
  logic [WORD_W-1:0]   pk_word;
  logic                pk_valid;
  logic                len_too_big;
  logic                len_zero;

  assign accepting = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_SUM);

  byte_packer #(
    .WORD_BYTES (WORD_BYTES),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_packer (
    .clk_i        (CLK),
    .rst_ni       (RST_N),
    .byte_i       (rx_data),
    .valid_i      (rx_valid & accepting),
    .clear_i      (arm | abort),
    .word_o       (pk_word),
    .word_valid_o (pk_valid)
  );

  // Header decode and running values for the word completing this cycle.
  always_comb begin
    len_too_big = CMP_W'(pk_word) > CAPACITY;
    len_zero    = (pk_word == '0);
    n_d         = (ADDR_WIDTH + 1)'(pk_word);
    wc_d        = wc_q + (ADDR_WIDTH + 1)'(1);
    chk_d       = chk_q ^ pk_word;
  end

  // Loader FSM with registered write port and status; abort beats arm.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      chk_q      <= '0;
      wc_q       <= '0;
      n_q        <= '0;
      chk_ok_q   <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      if (abort) begin
        state_q <= S_IDLE;
      end else if (arm) begin
        state_q  <= S_LEN;
        chk_q    <= '0;
        wc_q     <= '0;
        chk_ok_q <= 1'b0;
      end else if (pk_valid) begin
        unique case (state_q)
          S_LEN: begin
            if (len_too_big) begin
              state_q <= S_ERR;
            end else if (len_zero) begin
              state_q <= S_SUM;
            end else begin
              n_q     <= n_d;
              state_q <= S_DATA;
            end
          end
          S_DATA: begin
            mem_we_q   <= 1'b1;
            mem_addr_q <= wc_q[ADDR_WIDTH-1:0];
            mem_data_q <= pk_word;
            chk_q      <= chk_d;
            wc_q       <= wc_d;
            if (wc_d == n_q) state_q <= S_SUM;
          end
          S_SUM: begin
            chk_ok_q <= (pk_word == chk_q);
            state_q  <= S_DONE;
          end
          default: ;
        endcase
      end
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign busy       = accepting;
  assign done       = (state_q == S_DONE);
  assign err_len    = (state_q == S_ERR);
  assign chk_ok     = chk_ok_q;
  assign word_count = wc_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: little-endian and big-endian instances
// share one stimulus stream; writes are logged per instance.
`timescale 1ns/1ps
module tb_prog_loader;

  localparam int AW = 6;
  localparam int WB = 4;
  localparam int WW = 8 * WB;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;

  logic          le_we, be_we;
  logic [AW-1:0] le_addr, be_addr;
  logic [WW-1:0] le_data, be_data;
  logic          le_busy, be_busy, le_done, be_done;
  logic          le_ok, be_ok, le_err, be_err;
  logic [AW:0]   le_wc, be_wc;

  int n_vec  = 0;
  int n_miss = 0;

  logic [AW-1:0] le_a[$];
  logic [WW-1:0] le_d[$];
  logic [AW-1:0] be_a[$];
  logic [WW-1:0] be_d[$];

  prog_loader #(.ADDR_WIDTH(AW), .WORD_BYTES(WB), .BIG_ENDIAN(0)) u_le (
    .CLK(CLK), .RST_N(RST_N), .rx_data(rx_data), .rx_valid(rx_valid),
    .arm(arm), .abort(abort), .mem_we(le_we), .mem_addr(le_addr),
    .mem_data(le_data), .busy(le_busy), .done(le_done), .chk_ok(le_ok),
    .err_len(le_err), .word_count(le_wc)
  );

  prog_loader #(.ADDR_WIDTH(AW), .WORD_BYTES(WB), .BIG_ENDIAN(1)) u_be (
    .CLK(CLK), .RST_N(RST_N), .rx_data(rx_data), .rx_valid(rx_valid),
    .arm(arm), .abort(abort), .mem_we(be_we), .mem_addr(be_addr),
    .mem_data(be_data), .busy(be_busy), .done(be_done), .chk_ok(be_ok),
    .err_len(be_err), .word_count(be_wc)
  );

  always #5 CLK = ~CLK;

  // Write logger, sampled mid-cycle.
  always @(negedge CLK) begin
    if (le_we) begin le_a.push_back(le_addr); le_d.push_back(le_data); end
    if (be_we) begin be_a.push_back(be_addr); be_d.push_back(be_data); end
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_vec++;
    if (obs !== want) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge CLK);
    rx_data  = b;
    rx_valid = 1'b1;
  endtask

  task automatic end_bytes();
    @(negedge CLK);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic pulse_arm();
    @(negedge CLK);
    rx_valid = 1'b0;
    arm      = 1'b1;
    @(negedge CLK);
    arm = 1'b0;
  endtask

  task automatic pulse_abort();
    @(negedge CLK);
    rx_valid = 1'b0;
    abort    = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0; rx_valid = 1'b0; arm = 1'b0; abort = 1'b0;
    tick(2);
    RST_N = 1'b1;
  endtask

  task automatic clear_logs();
    le_a.delete(); le_d.delete(); be_a.delete(); be_d.delete();
  endtask

  task automatic send_nominal(input logic [31:0] sum);
    send_word(32'h0000_0002);
    send_word(32'h4433_2211);
    send_word(32'h8877_6655);
    send_word(sum);
    end_bytes();
  endtask

  task automatic check_two_writes(input string p);
    check_val({p, "_nwr"}, 64'(le_a.size()), 64'd2);
    if (le_a.size() >= 2) begin
      check_val({p, "_a0"}, 64'(le_a[0]), 64'd0);
      check_val({p, "_d0"}, 64'(le_d[0]), 64'h4433_2211);
      check_val({p, "_a1"}, 64'(le_a[1]), 64'd1);
      check_val({p, "_d1"}, 64'(le_d[1]), 64'h8877_6655);
    end
  endtask

  logic [31:0] w, xs, w_first, w_last;

  initial begin
    do_reset();
    // Reset state.
    check_val("rst_we",   64'(le_we),   64'd0);
    check_val("rst_addr", 64'(le_addr), 64'd0);
    check_val("rst_data", 64'(le_data), 64'd0);
    check_val("rst_busy", 64'(le_busy), 64'd0);
    check_val("rst_done", 64'(le_done), 64'd0);
    check_val("rst_ok",   64'(le_ok),   64'd0);
    check_val("rst_err",  64'(le_err),  64'd0);
    check_val("rst_wc",   64'(le_wc),   64'd0);

    // Nominal load.
    clear_logs();
    pulse_arm();
    check_val("nom_busy", 64'(le_busy), 64'd1);
    send_nominal(32'hCC44_4444);
    check_val("nom_done_rise", 64'(le_done), 64'd1);
    tick(2);
    check_two_writes("nom");
    check_val("nom_done", 64'(le_done), 64'd1);
    check_val("nom_ok",   64'(le_ok),   64'd1);
    check_val("nom_wc",   64'(le_wc),   64'd2);
    check_val("nom_busy_end", 64'(le_busy), 64'd0);

    // Bad checksum.
    clear_logs();
    pulse_arm();
    check_val("bad_ok_clr", 64'(le_ok), 64'd0);
    send_nominal(32'h0000_0000);
    tick(2);
    check_two_writes("bad");
    check_val("bad_done", 64'(le_done), 64'd1);
    check_val("bad_ok",   64'(le_ok),   64'd0);

    // Zero length.
    clear_logs();
    pulse_arm();
    send_word(32'h0);
    send_word(32'h0);
    end_bytes();
    tick(2);
    check_val("zero_nwr",  64'(le_a.size()), 64'd0);
    check_val("zero_done", 64'(le_done), 64'd1);
    check_val("zero_ok",   64'(le_ok),   64'd1);
    check_val("zero_wc",   64'(le_wc),   64'd0);

    // Header 65 exceeds a 64-word memory.
    clear_logs();
    pulse_arm();
    send_word(32'h0000_0041);
    end_bytes();
    check_val("len65_err",  64'(le_err),  64'd1);
    check_val("len65_busy", 64'(le_busy), 64'd0);
    send_word(32'h1111_1111);
    send_word(32'h0000_0000);
    end_bytes();
    tick(2);
    check_val("len65_nwr",  64'(le_a.size()), 64'd0);
    check_val("len65_hold", 64'(le_err),  64'd1);
    check_val("len65_done", 64'(le_done), 64'd0);

    // Header 64 fills the memory exactly.
    clear_logs();
    pulse_arm();
    check_val("len64_errclr", 64'(le_err), 64'd0);
    send_word(32'h0000_0040);
    xs = '0;
    for (int i = 0; i < 64; i++) begin
      w = {8'(i), 8'hA5, 8'(255 - i), 8'(i + 3)};
      if (i == 0)  w_first = w;
      if (i == 63) w_last  = w;
      xs ^= w;
      send_word(w);
    end
    send_word(xs);
    end_bytes();
    tick(2);
    check_val("len64_nwr", 64'(le_a.size()), 64'd64);
    if (le_a.size() == 64) begin
      check_val("len64_a0",  64'(le_a[0]),  64'd0);
      check_val("len64_d0",  64'(le_d[0]),  64'(w_first));
      check_val("len64_a63", 64'(le_a[63]), 64'd63);
      check_val("len64_d63", 64'(le_d[63]), 64'(w_last));
    end
    check_val("len64_done", 64'(le_done), 64'd1);
    check_val("len64_ok",   64'(le_ok),   64'd1);
    check_val("len64_wc",   64'(le_wc),   64'd64);

    // Abort after the 5th payload byte, then reload.
    clear_logs();
    pulse_arm();
    send_word(32'h0000_0002);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h44); send_byte(8'h55);
    pulse_abort();
    check_val("abt_busy", 64'(le_busy), 64'd0);
    send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    end_bytes();
    tick(2);
    check_val("abt_nwr",  64'(le_a.size()), 64'd1);
    check_val("abt_wc",   64'(le_wc),   64'd1);
    check_val("abt_done", 64'(le_done), 64'd0);
    clear_logs();
    pulse_arm();
    send_nominal(32'hCC44_4444);
    tick(2);
    check_two_writes("rld");
    check_val("rld_done", 64'(le_done), 64'd1);
    check_val("rld_ok",   64'(le_ok),   64'd1);
    check_val("rld_wc",   64'(le_wc),   64'd2);

    // arm and abort together leave the block idle.
    @(negedge CLK);
    arm = 1'b1; abort = 1'b1;
    @(negedge CLK);
    arm = 1'b0; abort = 1'b0;
    check_val("armabt_busy", 64'(le_busy), 64'd0);
    check_val("armabt_done", 64'(le_done), 64'd0);

    // Big-endian instance, back-to-back bytes.
    do_reset();
    clear_logs();
    pulse_arm();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    end_bytes();
    tick(2);
    check_val("be_nwr", 64'(be_a.size()), 64'd1);
    if (be_a.size() >= 1) begin
      check_val("be_a0", 64'(be_a[0]), 64'd0);
      check_val("be_d0", 64'(be_d[0]), 64'h1122_3344);
    end
    check_val("be_done", 64'(be_done), 64'd1);
    check_val("be_ok",   64'(be_ok),   64'd1);
    check_val("be_wc",   64'(be_wc),   64'd1);

    // Reset mid-header clears busy without waiting for a clock edge.
    pulse_arm();
    send_byte(8'h00); send_byte(8'h00);
    end_bytes();
    check_val("be_busy_pre", 64'(be_busy), 64'd1);
    #2 RST_N = 1'b0;
    #1;
    check_val("be_busy_rst", 64'(be_busy), 64'd0);
    check_val("be_ok_rst",   64'(be_ok),   64'd0);
    check_val("be_wc_rst",   64'(be_wc),   64'd0);
    tick(2);
    RST_N = 1'b1;
    tick(2);
    check_val("be_idle_post", 64'(be_busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Parametrised UART program loader that sits between the UART receiver and the instruction memory. It replaces the free-running byte-packing loop of the LOAD mode with a framed protocol: a word-count header, the payload words, then an XOR checksum word. It writes each assembled word to instruction memory and reports completion, checksum status and length errors to the mode controller before EXEC is entered.

## Interface
Parameters:
- `ADDR_WIDTH`, 17: instruction-memory word address width.
- `WORD_BYTES`, 4: bytes per instruction word; word width is `8*WORD_BYTES`.
- `BIG_ENDIAN`, 0: 0 means the first byte received lands in bits [7:0]; 1 means the first byte received lands in the top byte.

Ports:
- `CLK` in 1: single clock.
- `RST_N` in 1: reset, asynchronous, active-low.
- `rx_data` in 8: byte from the UART receiver.
- `rx_valid` in 1: one-cycle strobe qualifying `rx_data`.
- `arm` in 1: one-cycle pulse that starts a new load.
- `abort` in 1: one-cycle pulse that cancels the load and returns to IDLE.
- `mem_we` out 1: write strobe to instruction memory.
- `mem_addr` out `ADDR_WIDTH`: word address.
- `mem_data` out `8*WORD_BYTES`: word to write.
- `busy` out 1: high in LEN, DATA and SUM.
- `done` out 1: high in DONE.
- `chk_ok` out 1: checksum matched. Valid while `done` is high.
- `err_len` out 1: header length exceeds capacity. High in ERR.
- `word_count` out `ADDR_WIDTH+1`: number of payload words written so far.

## Operation
- States:
  - IDLE: reset state.
  - LEN: receiving the header.
  - DATA: receiving payload words.
  - SUM: receiving the checksum word.
  - DONE: load finished.
  - ERR: header length rejected.
- Byte packing:
  - A byte index counter runs 0..`WORD_BYTES-1`, and a shift/insert register assembles each word according to `BIG_ENDIAN`.
  - A word is complete when the byte at index `WORD_BYTES-1` is accepted.
  - The index then wraps to 0.
- Byte acceptance:
  - Bytes are accepted only in LEN, DATA and SUM.
  - `rx_valid` in IDLE, DONE or ERR is ignored.
- LEN:
  - The complete word is N, the payload word count, compared as an unsigned `8*WORD_BYTES`-bit value.
  - If N > 2^`ADDR_WIDTH`: go to ERR and set `err_len`.
  - If N == 0: go to SUM.
  - Otherwise: go to DATA.
- DATA:
  - Each completed word is written to `mem_addr` = `word_count`.
  - The word is XORed into the running checksum, and `word_count` increments.
  - After the Nth word, go to SUM.
- SUM:
  - The completed word is compared with the running XOR.
  - Go to DONE with `chk_ok` = match.
  - No memory write occurs in SUM.
- `arm` (accepted in any state except when `abort` is also high):
  - Clears the byte index, checksum, `word_count`, `chk_ok` and `err_len`.
  - Moves to LEN.
  - A byte presented in the same cycle as `arm` is discarded.
- `abort`:
  - Moves to IDLE from any state and clears the byte index.
  - No `mem_we` is issued after it.
  - `word_count` holds its value until the next `arm`.
  - `abort` wins over a simultaneous `arm`.
- Width rules:
  - `word_count` is `ADDR_WIDTH+1` bits so that N = 2^`ADDR_WIDTH` is representable.
  - `mem_addr` is the low `ADDR_WIDTH` bits of `word_count`.

## Timing
- Reset values: state IDLE; all outputs 0; byte index, checksum and N all 0.
- `mem_we`, `mem_addr` and `mem_data` are registered:
  - `mem_we` pulses for exactly one cycle, one cycle after the final byte of a payload word is accepted.
  - `mem_addr` and `mem_data` are stable during that cycle.
- Back-to-back `rx_valid` (one byte per cycle) must be sustained with no byte loss.
- `done` and `err_len` rise one cycle after the final byte of the checksum word or header, respectively.
- `busy` follows the state register with no combinational path from inputs.
- Reset asserted mid-load: outputs clear immediately (asynchronously) and state returns to IDLE. A `mem_we` in flight is cancelled.

## Structure
- Package `loader_pkg`:
  - State enum `loader_state_t` (IDLE, LEN, DATA, SUM, DONE, ERR).
  - Helper function for the byte-lane insert position given index and `BIG_ENDIAN`.
- Sub-module `byte_packer`:
  - Parameters: `WORD_BYTES`, `BIG_ENDIAN`.
  - Inputs: byte, valid, clear.
  - Outputs: word, `word_valid` (one-cycle).
- Top FSM: length check, checksum, address counter and write register.

## Test plan
All scenarios use `WORD_BYTES`=4, `ADDR_WIDTH`=6 and byte spacing of one cycle unless noted.
- Nominal load: `arm`, then bytes 02 00 00 00, 11 22 33 44, 55 66 77 88, 44 44 44 CC.
  - Required: `mem_we` at addr 0 with 0x44332211, then at addr 1 with 0x88776655.
  - Required: `done`=1, `chk_ok`=1, `word_count`=2.
- Bad checksum: the same stream with checksum 00 00 00 00.
  - Required: both writes occur, `done`=1, `chk_ok`=0.
- Zero length: `arm`, then 00 00 00 00, 00 00 00 00.
  - Required: no `mem_we`, `done`=1, `chk_ok`=1, `word_count`=0.
- Length bounds:
  - Header 41 00 00 00 (65): required `err_len`=1, state ERR, no writes, later bytes ignored.
  - Header 40 00 00 00 (64): accepted, and the last write goes to addr 63.
- Abort and reload: `abort` after the 5th payload byte.
  - Required: `busy`=0 and no further `mem_we`.
  - Then `arm` plus the full nominal stream reproduces the nominal result, confirming the byte index was reset.
  - Additionally, `arm` and `abort` in the same cycle leave the block in IDLE.
- Big-endian: `BIG_ENDIAN`=1 with bytes sent in back-to-back cycles; stream 00 00 00 01, 11 22 33 44, 11 22 33 44.
  - Required: write 0x11223344 at addr 0, `done`=1, `chk_ok`=1.
  - Required: reset pulsed mid-header clears `busy` in the same cycle.
